uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_CH, 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, 8, character width.
REQ-003 Parameter: TIMEOUT, 255, idle cycles before a locked grant is revoked (1..65535).
REQ-004 Port: clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: req_valid  input  NUM_CH  per-channel character available.
REQ-007 Port: req_data  input  NUM_CH*WIDTH  per-channel character; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: req_last  input  NUM_CH  marks the final character of a message; qualified by req_valid.
REQ-009 Port: req_ready  output  NUM_CH  per-channel accept; combinational.
REQ-010 Port: tx_data  output  WIDTH  character to the transmitter FIFO; registered.
REQ-011 Port: tx_strobe  output  1  FIFO write strobe; registered, one-cycle pulse.
REQ-012 Port: tx_full  input  1  transmitter FIFO full.
REQ-013 Port: grant  output  NUM_CH  one-hot owner of the transmitter, or all-zero; registered.
REQ-014 Port: busy  output  1  high whenever grant is non-zero.

Function
REQ-015 FSM states: IDLE, LOCK and GAP.
REQ-016 IDLE:
- When any req_valid is high, the block shall grant the first requesting channel after last_owner, searching upward and wrapping at NUM_CH-1 to 0.
- The granted channel shall be loaded into grant, and the FSM shall move to LOCK on the next cycle.
- Arbitration latency is 1 cycle.
REQ-017 IDLE: no req_valid -> the FSM shall remain in IDLE with grant all-zero.
REQ-018 req_ready[i] = (state==LOCK) & grant[i] & ~tx_full.
- All non-granted channels shall see req_ready low.
REQ-019 LOCK: transfer occurs on the cycle where req_valid[g] & req_ready[g] is high.
- tx_data shall be loaded with req_data[g].
- tx_strobe shall be 1 in the following cycle.
- The FSM shall move to GAP.
REQ-020 GAP: tx_strobe shall be 0 in the following cycle.
- This guarantees a low cycle between strobes, because the FIFO writes on the strobe rising edge.
- Maximum throughput is 1 character per 2 cycles.
REQ-021 GAP exit:
- If the transferred character had req_last=1, the FSM shall go to IDLE, last_owner shall be set to g, and grant shall be cleared.
- Otherwise the FSM shall return to LOCK with grant held.
REQ-022 Message atomicity: grant shall not change between a channel's first transfer and its req_last transfer, except on timeout or reset.
REQ-023 LOCK with tx_full=1: there shall be no transfer and no strobe.
- Grant shall be held indefinitely.
- The timeout counter shall not advance, because backpressure is not idleness.
REQ-024 Timeout counter: it shall increment each LOCK cycle where req_valid[g]=0 and tx_full=0.
- It shall clear on any transfer or state change.
- On reaching TIMEOUT, the FSM shall go to IDLE, last_owner shall be set to g, and grant shall be cleared.
REQ-025 tx_full rising in the same cycle as a LOCK transfer attempt: req_ready is low, so no transfer occurs.
REQ-026 tx_data shall hold its last value when tx_strobe=0.
REQ-027 A requester deasserting req_valid without transfer is legal; the arbiter shall not latch unaccepted data.
REQ-028 Counter width shall be the ceiling log2 of TIMEOUT+1. Round-robin pointer width shall be the ceiling log2 of NUM_CH.

Reset
REQ-029 When rst=1 at posedge clk, the block shall enter the following values:
- state=IDLE
- grant=0, busy=0
- tx_strobe=0, tx_data=0
- timeout counter=0
- last_owner=NUM_CH-1, so channel 0 has first priority
REQ-030 Reset mid-message shall abandon the message with no strobe in the cycle after reset. An in-flight strobe shall be forced low.
REQ-031 req_ready shall be 0 for every channel while rst=1.

Verification
REQ-032 Reset, then all four channels valid with data 0x41/0x42/0x43/0x44 and last=1 -> grants in order ch0, ch1, ch2, ch3; tx_strobe pulses carry 0x41, 0x42, 0x43, 0x44; strobes are never on adjacent cycles.
REQ-033 Ch1 sends "Hi\r\n" with last on 0x0A while ch2 requests throughout -> the strobe sequence is 0x48, 0x69, 0x0D, 0x0A, all from ch1; ch2 is granted the cycle after ch1 returns to IDLE.
REQ-034 tx_full=1 for 50 cycles in LOCK with ch0 valid -> req_ready[0]=0, no strobe, grant held, no timeout; transfer occurs on the first cycle after tx_full falls.
REQ-035 TIMEOUT=8, ch3 granted, sends 0x31 without last, then drops req_valid -> grant is cleared after 8 idle LOCK cycles; the next pending requester, ch0, is granted.
REQ-036 rst asserted on the cycle tx_strobe=1 -> tx_strobe=0 and grant=0 on the next cycle; after release, ch0 wins if requesting.
REQ-037 Ch2 alone sends 3 characters with last on the third -> exactly 3 strobes with 1-cycle gaps; busy falls 1 cycle after the third strobe.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one requester onto the UART transmitter FIFO for a whole message,
// inserting a low cycle between write strobes and revoking an idle lock after TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]       req_last,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [WIDTH-1:0]        tx_data,
  output logic                    tx_strobe,
  input  logic                    tx_full,
  output logic [NUM_CH-1:0]       grant,
  output logic                    busy
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOCK, GAP} state_t;

  state_t            state, state_nx;
  logic [NUM_CH-1:0] grant_nx;
  logic [PTR_W-1:0]  last_owner, last_owner_nx;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  winner;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [WIDTH-1:0]  tx_data_nx;
  logic              tx_strobe_nx;
  logic              last_flag, last_flag_nx;
  logic              xfer;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) owner = PTR_W'(i);
    end
  end

  // Walk downward so the closest requester after last_owner is the final assignment.
  always_comb begin
    winner = last_owner;
    for (int k = NUM_CH; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner) + k) % NUM_CH;
      if (req_valid[idx]) winner = PTR_W'(idx);
    end
  end

  assign req_ready = (state == LOCK && !rst && !tx_full) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign busy      = |grant;

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_owner_nx = last_owner;
    cnt_nx        = '0;
    tx_data_nx    = tx_data;
    tx_strobe_nx  = 1'b0;
    last_flag_nx  = last_flag;
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (|req_valid) begin
          grant_nx = NUM_CH'(1) << winner;
          state_nx = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          tx_data_nx   = req_data[owner*WIDTH +: WIDTH];
          tx_strobe_nx = 1'b1;
          last_flag_nx = req_last[owner];
          state_nx     = GAP;
        end else if (!tx_full && !req_valid[owner]) begin
          if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nx      = IDLE;
            last_owner_nx = owner;
            grant_nx      = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else begin
          // Backpressure is not idleness: hold the count.
          cnt_nx = cnt;
        end
      end
      GAP: begin
        if (last_flag) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
          grant_nx      = '0;
        end else begin
          state_nx = LOCK;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= PTR_W'(NUM_CH - 1);
      cnt        <= '0;
      tx_data    <= '0;
      tx_strobe  <= 1'b0;
      last_flag  <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_owner <= last_owner_nx;
      cnt        <= cnt_nx;
      tx_data    <= tx_data_nx;
      tx_strobe  <= tx_strobe_nx;
      last_flag  <= last_flag_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level model predicts grant, ready and strobes
// every cycle, with a directed all-channels opening burst followed by random traffic mixes.
module tb_uart_tx_arbiter;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;
  localparam int CYCLES  = 3000;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       req_valid = '0;
  logic [NUM_CH*WIDTH-1:0] req_data = '0;
  logic [NUM_CH-1:0]       req_last = '0;
  logic [NUM_CH-1:0]       req_ready;
  logic [WIDTH-1:0]        tx_data;
  logic                    tx_strobe;
  logic                    tx_full = 1'b0;
  logic [NUM_CH-1:0]       grant;
  logic                    busy;

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_full(tx_full),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the transmitter, whether the char just sent is cooling down, idle streak.
  int owner    = -1;
  bit cooling  = 0;
  bit msg_end  = 0;
  int prev_own = NUM_CH - 1;
  int idle_run = 0;
  bit m_strobe = 0;
  int m_data   = 0;

  task automatic model_step();
    bit strobe_next;
    strobe_next = 0;
    if (rst) begin
      owner = -1; cooling = 0; msg_end = 0; prev_own = NUM_CH - 1;
      idle_run = 0; m_data = 0;
    end else if (owner < 0) begin
      for (int k = NUM_CH; k >= 1; k--)
        if (req_valid[(prev_own + k) % NUM_CH]) owner = (prev_own + k) % NUM_CH;
      idle_run = 0;
    end else if (cooling) begin
      cooling = 0;
      idle_run = 0;
      if (msg_end) begin
        prev_own = owner;
        owner = -1;
      end
    end else if (!tx_full && req_valid[owner]) begin
      m_data = int'(req_data[owner*WIDTH +: WIDTH]);
      strobe_next = 1;
      cooling = 1;
      msg_end = req_last[owner];
      idle_run = 0;
    end else if (!tx_full) begin
      idle_run++;
      if (idle_run == TIMEOUT) begin
        prev_own = owner;
        owner = -1;
        idle_run = 0;
      end
    end
    m_strobe = strobe_next;
  endtask

  function automatic logic [31:0] exp_grant();
    return (owner < 0) ? 32'd0 : (32'd1 << owner);
  endfunction

  initial begin
    bit prev_strobe;
    int pct_v, pct_l, pct_f, pct_r;
    prev_strobe = 0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      if (c < 3) begin
        rst = 1'b1; tx_full = 1'b0; req_valid = '0;
      end else if (c < 40) begin
        rst = 1'b0; tx_full = 1'b0;
        req_valid = '1; req_last = '1;
        req_data = {8'h44, 8'h43, 8'h42, 8'h41};
      end else begin
        case ((c / 500) % 4)
          0: begin pct_v = 70; pct_l = 30; pct_f = 20; pct_r = 1; end
          1: begin pct_v = 12; pct_l = 40; pct_f = 5;  pct_r = 0; end
          2: begin pct_v = 80; pct_l = 20; pct_f = 70; pct_r = 1; end
          default: begin pct_v = 50; pct_l = 50; pct_f = 0; pct_r = 2; end
        endcase
        rst = ($urandom_range(99) < pct_r);
        tx_full = ($urandom_range(99) < pct_f);
        for (int i = 0; i < NUM_CH; i++) begin
          req_valid[i] = ($urandom_range(99) < pct_v);
          req_last[i]  = ($urandom_range(99) < pct_l);
          req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      #1;
      if (c > 0) begin
        check_val("grant", 32'(grant), exp_grant());
        check_val("busy", 32'(busy), 32'(owner >= 0));
        check_val("tx_strobe", 32'(tx_strobe), 32'(m_strobe));
        check_val("tx_data", 32'(tx_data), m_data);
        check_val("req_ready", 32'(req_ready),
                  (!rst && owner >= 0 && !cooling && !tx_full) ? exp_grant() : 32'd0);
        check_val("strobe_gap", 32'(prev_strobe & tx_strobe), 32'd0);
        prev_strobe = tx_strobe;
      end
      @(posedge clk);
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
